// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared state encoding and default width for the sequential multiplier
package seq_mult_pkg;
  localparam int W_DEF = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/seq_mult_dp.sv
// seq_mult_dp: shift-and-add datapath (accumulator, shifting multiplicand/multiplier, one 2W adder)
//   clk, res        clock, async active-low reset
//   load_i          capture a_i/b_i and clear the accumulator
//   step_i          perform one add/shift iteration
//   a_i, b_i        operands
//   mr_rest_zero_o  no set multiplier bits above bit 0 (only with SEQ_MULT_EARLY_TERM_EN)
//   acc_nxt_o       accumulator value after the current iteration's conditional add
module seq_mult_dp import seq_mult_pkg::*; #(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           res,
  input  logic           load_i,
  input  logic           step_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
`ifdef SEQ_MULT_EARLY_TERM_EN
  output logic           mr_rest_zero_o,
`endif
  output logic [2*W-1:0] acc_nxt_o
);
  logic [2*W-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [W-1:0]   mr_q, mr_d;
  logic           mr_lsb;
  assign mr_lsb = mr_q[0];
  // operands are at most W bits each, so the 2W-bit sum never carries out
  assign acc_nxt_o = mr_lsb ? acc_q + mcand_q : acc_q;
`ifdef SEQ_MULT_EARLY_TERM_EN
  assign mr_rest_zero_o = (mr_q >> 1) == '0;
`endif
  always_comb begin
    acc_d   = load_i ? '0 : step_i ? acc_nxt_o : acc_q;
    mcand_d = load_i ? {{W{1'b0}}, a_i} : step_i ? mcand_q << 1 : mcand_q;
    mr_d    = load_i ? b_i : step_i ? mr_q >> 1 : mr_q;
  end
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      acc_q   <= '0;
      mcand_q <= '0;
      mr_q    <= '0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mr_q    <= mr_d;
    end
  end
endmodule

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: start/busy/done sequencer for an unsigned W x W -> 2W shift-and-add multiplier
//   clk, res   clock, async active-low reset
//   start      request, accepted only in IDLE; a/b captured on that edge
//   busy       high in RUN and DONE
//   done       one-cycle pulse, p valid while high
//   p          registered product, held until the next completion
// Build option: SEQ_MULT_EARLY_TERM_EN ends RUN once no multiplier bits remain.
module seq_mult_ctrl import seq_mult_pkg::*; #(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           res,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] p
);
  localparam int CNT_W = $clog2(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2*W-1:0]   p_q, acc_nxt;
  logic             busy_q, done_q, load, step, last;
  assign load = state_q == IDLE && start;
  assign step = state_q == RUN;
`ifdef SEQ_MULT_EARLY_TERM_EN
  logic mr_rest_zero;
  // cnt exit stays as a backstop even though mr empties by then
  assign last = cnt_q == CNT_LAST || mr_rest_zero;
`else
  assign last = cnt_q == CNT_LAST;
`endif
  seq_mult_dp #(.W(W)) u_dp (
    .clk            (clk),
    .res            (res),
    .load_i         (load),
    .step_i         (step),
    .a_i            (a),
    .b_i            (b),
`ifdef SEQ_MULT_EARLY_TERM_EN
    .mr_rest_zero_o (mr_rest_zero),
`endif
    .acc_nxt_o      (acc_nxt)
  );
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            state_q <= DONE;
            p_q     <= acc_nxt;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign p    = p_q;
endmodule
